// File: rtl/img_pkg.sv
// Shared types and constants for the edge-detection frame sink.
package img_pkg;

    localparam int PIX_W     = 4;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    // Wide enough for any practical frame; the top narrows it to ADDR_W.
    localparam int WE_ADDR_W = 32;

    typedef struct packed {
        logic [WE_ADDR_W-1:0] addr;
        logic [PIX_W-1:0]     data;
    } wr_entry_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        DRAIN  = 3'd2,
        CLEAR  = 3'd3,
        DONE   = 3'd4
    } writer_state_t;

endpackage

// File: rtl/edge_frame_writer_if.sv
// Frame-memory write port.
//
// Handshake: the master raises mem_wr_req with mem_wr_addr/mem_wr_data; the
// write completes on a cycle where mem_wr_req && mem_wr_gnt. While req is high
// and gnt low, addr and data hold stable and req stays high. The only time req
// drops without a grant is when a new frame_start aborts the frame.
interface edge_frame_writer_if #(
    parameter int ADDR_W = 19
) ();

    logic                        mem_wr_req;
    logic [ADDR_W-1:0]           mem_wr_addr;
    logic [img_pkg::PIX_W-1:0]   mem_wr_data;
    logic                        mem_wr_gnt;

    modport master (
        output mem_wr_req,
        output mem_wr_addr,
        output mem_wr_data,
        input  mem_wr_gnt
    );

    modport slave (
        input  mem_wr_req,
        input  mem_wr_addr,
        input  mem_wr_data,
        output mem_wr_gnt
    );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; push is accepted when full if a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = store[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/edge_frame_writer.sv
// Writes filter magnitudes to frame memory at their window-centre address,
// buffering through a FIFO, then zero-fills the 2-pixel border.
module edge_frame_writer
    import img_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = $clog2(IMG_W * IMG_H)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [PIX_W-1:0]    pixel_in,
    input  logic                in_valid,
    edge_frame_writer_if.master mem,
    output logic                busy,
    output logic                frame_done,
    output logic                overflow,
    output writer_state_t       fsm_state
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = ADDR_W + PIX_W;
    localparam logic [XW-1:0]     XMAX       = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     YMAX       = YW'(IMG_H - 1);
    // Centre of the window ending at sample k sits 2 rows and 2 columns back.
    localparam logic [ADDR_W-1:0] CADDR_INIT = ADDR_W'(0) - ADDR_W'(2 * IMG_W + 2);

    writer_state_t     state, state_nx;
    logic [XW-1:0]     x, cur_x, bx;
    logic [YW-1:0]     y, cur_y, by;
    logic [ADDR_W-1:0] caddr, cur_caddr, baddr;
    logic              take, win_valid, last_sample;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;
    wr_entry_t         push_entry, head;
    logic              write_state, border_mid, border_last;

    assign fsm_state   = state;
    assign write_state = (state == STREAM) || (state == DRAIN);

    // Current sample position; a frame_start sample is always k = 0.
    always_comb begin
        cur_x       = frame_start ? '0 : x;
        cur_y       = frame_start ? '0 : y;
        cur_caddr   = frame_start ? CADDR_INIT : caddr;
        take        = in_valid && (frame_start || state == STREAM);
        win_valid   = take && (cur_x >= XW'(4)) && (cur_y >= YW'(4));
        last_sample = take && (cur_x == XMAX) && (cur_y == YMAX);
    end

    // Column/row/centre-address counters advance per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x     <= '0;
            y     <= '0;
            caddr <= CADDR_INIT;
        end else if (take) begin
            if (cur_x == XMAX) begin
                x <= '0;
                y <= cur_y + YW'(1);
            end else begin
                x <= cur_x + XW'(1);
                y <= cur_y;
            end
            caddr <= cur_caddr + ADDR_W'(1);
        end else if (frame_start) begin
            x     <= '0;
            y     <= '0;
            caddr <= CADDR_INIT;
        end
    end

    // FIFO control: flush on frame_start, drop a valid sample only if full with no pop.
    always_comb begin
        fifo_pop        = write_state && !fifo_empty && mem.mem_wr_gnt && !frame_start;
        fifo_push       = win_valid && (!fifo_full || fifo_pop);
        drop            = win_valid && fifo_full && !fifo_pop;
        push_entry.addr = WE_ADDR_W'(cur_caddr);
        push_entry.data = pixel_in;
        fifo_wdata      = {ADDR_W'(push_entry.addr), push_entry.data};
        head.addr       = WE_ADDR_W'(fifo_rdata[FW-1:PIX_W]);
        head.data       = fifo_rdata[PIX_W-1:0];
    end

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (frame_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign border_mid  = (by >= YW'(2)) && (by <= YW'(IMG_H - 3));
    assign border_last = (by == YMAX) && (bx == XMAX);

    // Border walk: full top rows, 4 edge columns per middle row, full bottom rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx    <= '0;
            by    <= '0;
            baddr <= '0;
        end else if (state != CLEAR || frame_start) begin
            bx    <= '0;
            by    <= '0;
            baddr <= '0;
        end else if (mem.mem_wr_gnt) begin
            if (bx == XMAX) begin
                bx    <= '0;
                by    <= by + YW'(1);
                baddr <= baddr + ADDR_W'(1);
            end else if (border_mid && bx == XW'(1)) begin
                bx    <= XW'(IMG_W - 2);
                baddr <= baddr + ADDR_W'(IMG_W - 3);
            end else begin
                bx    <= bx + XW'(1);
                baddr <= baddr + ADDR_W'(1);
            end
        end
    end

    // Write-port mux: FIFO head while streaming/draining, border zeros in CLEAR.
    always_comb begin
        mem.mem_wr_req  = 1'b0;
        mem.mem_wr_addr = '0;
        mem.mem_wr_data = '0;
        if (write_state && !fifo_empty) begin
            mem.mem_wr_req  = 1'b1;
            mem.mem_wr_addr = ADDR_W'(head.addr);
            mem.mem_wr_data = head.data;
        end else if (state == CLEAR) begin
            mem.mem_wr_req  = 1'b1;
            mem.mem_wr_addr = baddr;
        end
    end

    // Next-state logic; frame_start restarts from any state.
    always_comb begin
        state_nx = state;
        if (frame_start) begin
            state_nx = STREAM;
        end else begin
            case (state)
                IDLE:    state_nx = IDLE;
                STREAM:  if (last_sample) state_nx = DRAIN;
                DRAIN:   if (fifo_empty) state_nx = CLEAR;
                CLEAR:   if (mem.mem_wr_gnt && border_last) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // State, registered status outputs and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != IDLE);
            frame_done <= (state == DONE);
            if (frame_start)  overflow <= 1'b0;
            else if (drop)    overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_frame_writer.sv
// Bench for edge_frame_writer on an 8x6 frame with a 4-entry write buffer.
module tb_edge_frame_writer;
    import img_pkg::*;

    localparam int W     = 8;
    localparam int H     = 6;
    localparam int DEPTH = 4;
    localparam int AW    = 6;

    logic          clk         = 1'b0;
    logic          rst_n       = 1'b1;
    logic          frame_start = 1'b0;
    logic          in_valid    = 1'b0;
    logic [3:0]    pixel_in    = 4'd0;
    logic          busy;
    logic          frame_done;
    logic          overflow;
    writer_state_t fsm_state;

    edge_frame_writer_if #(.ADDR_W(AW)) mem_bus ();

    edge_frame_writer #(
        .IMG_W      (W),
        .IMG_H      (H),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pixel_in    (pixel_in),
        .in_valid    (in_valid),
        .mem         (mem_bus),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    int            total    = 0;
    int            bad      = 0;
    int            done_cnt = 0;
    int            gnt_mode = 0;
    int            base;
    logic [AW+3:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [AW+3:0] prev_word;
    logic [AW+3:0] word;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Grant driver: 0 = low, 1 = high, 2 = toggle every cycle
    initial begin
        mem_bus.mem_wr_gnt = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       mem_bus.mem_wr_gnt = 1'b0;
                1:       mem_bus.mem_wr_gnt = 1'b1;
                default: mem_bus.mem_wr_gnt = ~mem_bus.mem_wr_gnt;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            word = {mem_bus.mem_wr_addr, mem_bus.mem_wr_data};
            if (mem_bus.mem_wr_req && hold_prev)
                check("hold_stable", word, prev_word);
            if (mem_bus.mem_wr_req && mem_bus.mem_wr_gnt) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0d data %0d, required no write",
                             mem_bus.mem_wr_addr, mem_bus.mem_wr_data);
                end else begin
                    check("write", word, exp_q.pop_front());
                end
            end
            hold_prev = mem_bus.mem_wr_req && !mem_bus.mem_wr_gnt;
            prev_word = word;
            if (frame_done) done_cnt++;
        end
    end

    task automatic push_border();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                if (yy < 2 || yy > H - 3 || xx < 2 || xx > W - 3)
                    exp_q.push_back({AW'(yy * W + xx), 4'd0});
    endtask

    // dmode 0: all samples 5; otherwise sample k carries k mod 16.
    // max_keep: how many window-valid samples are expected to reach memory.
    task automatic send_samples(input int n, input int dmode, input int max_keep, input bit border);
        int         kept;
        logic [3:0] d;
        kept = 0;
        for (int k = 0; k < n; k++) begin
            d = (dmode == 0) ? 4'd5 : 4'(k);
            @(posedge clk);
            #1;
            frame_start = (k == 0);
            in_valid    = 1'b1;
            pixel_in    = d;
            if ((k % W) >= 4 && (k / W) >= 4) begin
                if (kept < max_keep) exp_q.push_back({AW'(k - (2 * W + 2)), d});
                kept++;
            end
        end
        if (border) push_border();
    endtask

    task automatic end_stream(input bit keep_valid);
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        in_valid    = keep_valid;
    endtask

    task automatic wait_frame(input int start_cnt, input string tag);
        int cyc;
        cyc = 0;
        while (done_cnt == start_cnt && cyc < 400) begin
            @(posedge clk);
            cyc++;
        end
        check({tag, "_done_in_time"}, int'(done_cnt > start_cnt), 1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt - start_cnt, 1);
        check({tag, "_all_writes"}, exp_q.size(), 0);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_state_idle"}, fsm_state, IDLE);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_req", mem_bus.mem_wr_req, 0);
        check("rst_addr", mem_bus.mem_wr_addr, 0);
        check("rst_data", mem_bus.mem_wr_data, 0);
        check("rst_state", fsm_state, IDLE);
        rst_n = 1'b1;

        // in_valid while IDLE is ignored
        in_valid = 1'b1;
        pixel_in = 4'd9;
        repeat (4) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_state", fsm_state, IDLE);
        check("idle_req", mem_bus.mem_wr_req, 0);
        in_valid = 1'b0;

        // Normal frame, gnt high, in_valid kept high through DONE and IDLE
        gnt_mode = 1;
        base = done_cnt;
        send_samples(48, 0, 99, 1'b1);
        end_stream(1'b1);
        wait_frame(base, "t1");
        check("t1_overflow", overflow, 0);
        in_valid = 1'b0;

        // gnt held low for 20 cycles from the first stream request
        gnt_mode = 0;
        base = done_cnt;
        fork
            send_samples(48, 0, DEPTH, 1'b1);
            begin
                int c;
                c = 0;
                while (!mem_bus.mem_wr_req && c < 200) begin
                    @(posedge clk);
                    #1;
                    c++;
                end
                check("t2_req_seen", mem_bus.mem_wr_req, 1);
                repeat (20) @(posedge clk);
                gnt_mode = 1;
            end
        join
        end_stream(1'b0);
        check("t2_overflow", overflow, 1);
        wait_frame(base, "t2");
        check("t2_overflow_sticky", overflow, 1);

        // gnt toggling every cycle
        gnt_mode = 2;
        base = done_cnt;
        send_samples(48, 1, 99, 1'b1);
        end_stream(1'b0);
        wait_frame(base, "t3");
        check("t3_overflow", overflow, 0);

        // Abort at k = 30, then a full frame
        gnt_mode = 1;
        base = done_cnt;
        send_samples(30, 1, 99, 1'b0);
        send_samples(48, 1, 99, 1'b1);
        end_stream(1'b0);
        wait_frame(base, "t4");

        // Abort at k = 46 with gnt low and a full FIFO; stale entries must vanish
        gnt_mode = 0;
        base = done_cnt;
        send_samples(46, 1, 0, 1'b0);
        fork
            send_samples(48, 0, 99, 1'b1);
            begin
                @(posedge clk);
                #2;
                check("t5_overflow_set", overflow, 1);
                @(posedge clk);
                gnt_mode = 1;
            end
        join
        end_stream(1'b0);
        wait_frame(base, "t5");
        check("t5_overflow_cleared", overflow, 0);

        // Reset mid-DRAIN with gnt low
        gnt_mode = 0;
        send_samples(48, 1, 0, 1'b0);
        end_stream(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t6_state_drain", fsm_state, DRAIN);
        check("t6_req_pending", mem_bus.mem_wr_req, 1);
        check("t6_overflow_pre", overflow, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", mem_bus.mem_wr_req, 0);
        check("t6_async_addr", mem_bus.mem_wr_addr, 0);
        check("t6_async_data", mem_bus.mem_wr_data, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_overflow", overflow, 0);
        check("t6_async_done", frame_done, 0);
        check("t6_async_state", fsm_state, IDLE);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        gnt_mode = 1;
        in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t6_post_busy", busy, 0);
        check("t6_post_state", fsm_state, IDLE);
        check("t6_post_req", mem_bus.mem_wr_req, 0);
        check("t6_post_overflow", overflow, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_writes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
